// File: rtl/fir_pkg.sv
// Shared types and helpers for the L-parallel fixed-point FIR datapath.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package fir_pkg;

    // Result of rounding/saturating one accumulator: clamped value plus clamp flag.
    typedef struct packed {
        logic               sat;
        logic signed [63:0] val;
    } rs_t;

    // Exact accumulator width: one full product plus growth for summing ntaps of them.
    function automatic int acc_width(input int dw, input int cw, input int ntaps);
        return dw + cw + $clog2(ntaps);
    endfunction

    // LSB position of lane `lane` inside a bus of w-bit lanes.
    function automatic int lane_lsb(input int lane, input int w);
        return lane * w;
    endfunction

    // Round half up at bit `frac`, then clamp to the signed ow-bit range.
    // Callers sign-extend their accumulator to 64 bits; every supported width fits.
    function automatic rs_t round_sat(input logic signed [63:0] acc, input int frac, input int ow);
        logic signed [63:0] rnd;
        logic signed [63:0] shifted;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        rs_t                r;
        rnd     = (frac > 0) ? (64'sd1 <<< (frac - 1)) : 64'sd0;
        shifted = (acc + rnd) >>> frac;
        hi      = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (ow - 1));
        r.sat   = 1'b0;
        r.val   = shifted;
        if (shifted > hi) begin
            r.val = hi;
            r.sat = 1'b1;
        end else if (shifted < lo) begin
            r.val = lo;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_parallel_fx_if.sv
// Sample, coefficient-load and result bundle of the parallel FIR.
// Latency: none (wiring only).
// Backpressure: none; the source drives beats and the sink takes every result.
interface fir_parallel_fx_if #(
    parameter int L  = 2,
    parameter int DW = 16,
    parameter int CW = 16,
    parameter int OW = 16,
    parameter int AW = 4
);
    logic                 flush;
    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_data;
    logic                 coef_commit;
    logic                 in_valid;
    logic [L*DW-1:0]      in_data;
    logic                 out_valid;
    logic [L*OW-1:0]      out_data;
    logic [L-1:0]         out_sat;

    // Sample source / coefficient loader side.
    modport master (
        output flush, coef_we, coef_addr, coef_data, coef_commit, in_valid, in_data,
        input  out_valid, out_data, out_sat
    );

    // Filter side.
    modport slave (
        input  flush, coef_we, coef_addr, coef_data, coef_commit, in_valid, in_data,
        output out_valid, out_data, out_sat
    );
endinterface

// File: rtl/fir_mac_lane.sv
// One output phase of the parallel FIR: NTAPS products, adder tree, round and saturate.
// Latency: 2 cycles from i_x/i_h to o_y (product register, then result register).
// Backpressure: none; products advance every cycle, o_y only updates when i_vld is set.
module fir_mac_lane
    import fir_pkg::*;
#(
    parameter int NTAPS = 12,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int OW    = 16,
    parameter int FRAC  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_vld,
    input  logic signed [DW-1:0] i_x [NTAPS],
    input  logic signed [CW-1:0] i_h [NTAPS],
    output logic signed [OW-1:0] o_y,
    output logic                 o_sat
);
    localparam int PW = DW + CW;
    localparam int AW = acc_width(DW, CW, NTAPS);

    logic signed [PW-1:0] r_prod [NTAPS];
    logic signed [AW-1:0] w_acc;
    rs_t                  w_rs;
    logic signed [OW-1:0] r_y;
    logic                 r_sat;

    // Full-precision products for every tap, recomputed each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < NTAPS; t++) r_prod[t] <= '0;
        end else begin
            for (int t = 0; t < NTAPS; t++) r_prod[t] <= PW'(i_x[t]) * PW'(i_h[t]);
        end
    end

    // Exact sum of all taps; the accumulator is wide enough that no term is lost.
    always_comb begin
        w_acc = '0;
        for (int t = 0; t < NTAPS; t++) w_acc = w_acc + AW'(r_prod[t]);
        w_rs = round_sat(64'(w_acc), FRAC, OW);
    end

    // Result register: data holds between beats, the clamp flag only marks valid beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y   <= '0;
            r_sat <= 1'b0;
        end else if (i_vld) begin
            r_y   <= w_rs.val[OW-1:0];
            r_sat <= w_rs.sat;
        end else begin
            r_sat <= 1'b0;
        end
    end

    assign o_y   = r_y;
    assign o_sat = r_sat;

endmodule

// File: rtl/fir_parallel_fx.sv
// L-parallel fixed-point direct-form FIR with double-buffered runtime coefficients.
// Latency: 3 cycles, in_valid to out_valid (delay line, products, round/sat).
// Backpressure: none; the pipeline always advances and every accepted beat emits.
module fir_parallel_fx
    import fir_pkg::*;
#(
    parameter int NTAPS = 12,
    parameter int L     = 2,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int OW    = 16,
    parameter int FRAC  = 15
) (
    input logic               clk,
    input logic               rst,
    fir_parallel_fx_if.slave  bus
);
    localparam int            AW       = $clog2(NTAPS);
    localparam int            DL       = NTAPS - 1 + L;
    localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);

    // r_dl[i] is the sample of age i: index 0 is the newest lane of the latest beat.
    logic signed [DW-1:0] r_dl     [DL];
    logic signed [CW-1:0] r_shadow [NTAPS];
    logic signed [CW-1:0] r_active [NTAPS];
    logic                 r_v1;
    logic                 r_v2;
    logic                 r_v3;
    logic                 w_take;

    // A beat presented together with flush is dropped along with the history.
    assign w_take = bus.in_valid & ~bus.flush;

    // Delay line: shifts by L on an accepted beat, idle cycles leave history intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DL; i++) r_dl[i] <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < DL; i++) r_dl[i] <= '0;
        end else if (bus.in_valid) begin
            for (int i = 0; i < L; i++) begin
                r_dl[i] <= $signed(bus.in_data[lane_lsb(L - 1 - i, DW) +: DW]);
            end
            for (int i = L; i < DL; i++) r_dl[i] <= r_dl[i-L];
        end
    end

    // Coefficient banks: commit copies the shadow as it was before this edge's write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < NTAPS; t++) begin
                r_shadow[t] <= '0;
                r_active[t] <= '0;
            end
        end else begin
            if (bus.coef_commit) begin
                for (int t = 0; t < NTAPS; t++) r_active[t] <= r_shadow[t];
            end
            if (bus.coef_we && (bus.coef_addr <= LAST_TAP)) begin
                r_shadow[bus.coef_addr] <= bus.coef_data;
            end
        end
    end

    // Valid pipeline: delay line, product and result stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            r_v1 <= w_take;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    assign bus.out_valid = r_v3;

    for (genvar p = 0; p < L; p++) begin : g_lane
        logic signed [DW-1:0] w_x [NTAPS];
        logic signed [OW-1:0] w_y;
        logic                 w_sat;

        // Lane p sees its own sample at age L-1-p and the NTAPS-1 older ones behind it.
        always_comb begin
            for (int t = 0; t < NTAPS; t++) w_x[t] = r_dl[L - 1 - p + t];
        end

        fir_mac_lane #(
            .NTAPS (NTAPS),
            .DW    (DW),
            .CW    (CW),
            .OW    (OW),
            .FRAC  (FRAC)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .i_vld (r_v2),
            .i_x   (w_x),
            .i_h   (r_active),
            .o_y   (w_y),
            .o_sat (w_sat)
        );

        assign bus.out_data[p*OW +: OW] = w_y;
        assign bus.out_sat[p]           = w_sat;
    end

endmodule

// File: tb/tb_fir_parallel_fx.sv
module tb_fir_parallel_fx;
    localparam int NTAPS = 12;
    localparam int L     = 2;
    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int OW    = 16;
    localparam int FRAC  = 15;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir_parallel_fx_if #(.L(L), .DW(DW), .CW(CW), .OW(OW), .AW(AW)) bus ();

    fir_parallel_fx #(
        .NTAPS(NTAPS), .L(L), .DW(DW), .CW(CW), .OW(OW), .FRAC(FRAC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       vld;
        int         x0;
        int         x1;
        logic       e_vld;
        int         e0;
        int         e1;
        logic [1:0] e_sat;
    } vec_t;

    typedef struct {
        logic       vld;
        longint     y0;
        longint     y1;
        logic [1:0] sat;
    } exp_t;

    vec_t   vt [10];
    int     hv [NTAPS];
    int     ah [NTAPS];
    int     xs [$];
    exp_t   eq [$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint ly(input int p);
        return longint'($signed(bus.out_data[p*OW +: OW]));
    endfunction

    task automatic tick(input logic vld, input int x0, input int x1, input logic fl = 1'b0,
                        input logic we = 1'b0, input int addr = 0, input int data = 0,
                        input logic cm = 1'b0);
        bus.in_valid    = vld;
        bus.in_data     = {16'(x1), 16'(x0)};
        bus.flush       = fl;
        bus.coef_we     = we;
        bus.coef_addr   = 4'(addr);
        bus.coef_data   = 16'(data);
        bus.coef_commit = cm;
        @(posedge clk);
        #1;
    endtask

    task automatic load_bank();
        for (int t = 0; t < NTAPS; t++) tick(1'b0, 0, 0, 1'b0, 1'b1, t, hv[t], 1'b0);
        tick(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
        tick(1'b0, 0, 0);
    endtask

    // Reference: direct convolution over every sample since the last clear.
    function automatic void ref_y(input int n, output longint y, output logic s);
        longint acc;
        longint r;
        acc = 0;
        for (int t = 0; t < NTAPS; t++) begin
            if (n - t >= 0) acc += longint'(ah[t]) * longint'(xs[n-t]);
        end
        r = (acc + 16384) >>> 15;
        s = 1'b0;
        y = r;
        if (r > 32767) begin
            y = 32767;
            s = 1'b1;
        end else if (r < -32768) begin
            y = -32768;
            s = 1'b1;
        end
    endfunction

    initial begin
        longint last0, last1;
        int     ob;
        logic   vh [32];
        logic   ev;

        vt[0] = '{1'b1, 16384, 0, 1'b0, 0,    0,    2'b00};
        vt[1] = '{1'b1, 0,     0, 1'b0, 0,    0,    2'b00};
        vt[2] = '{1'b1, 0,     0, 1'b1, 512,  1024, 2'b00};
        vt[3] = '{1'b1, 0,     0, 1'b1, 1536, 2048, 2'b00};
        vt[4] = '{1'b1, 0,     0, 1'b1, 2560, 3072, 2'b00};
        vt[5] = '{1'b1, 0,     0, 1'b1, 3584, 4096, 2'b00};
        vt[6] = '{1'b1, 0,     0, 1'b1, 4608, 5120, 2'b00};
        vt[7] = '{1'b1, 0,     0, 1'b1, 5632, 6144, 2'b00};
        vt[8] = '{1'b1, 0,     0, 1'b1, 0,    0,    2'b00};
        vt[9] = '{1'b1, 0,     0, 1'b1, 0,    0,    2'b00};

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.flush = 1'b0;
        bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0; bus.coef_commit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset out_data", bus.out_data, 0);
        chk("reset out_sat", bus.out_sat, 0);
        @(negedge clk);
        rst = 1'b0;

        // Impulse response, table driven.
        for (int t = 0; t < NTAPS; t++) hv[t] = (t + 1) * 1024;
        load_bank();
        for (int i = 0; i < 10; i++) begin
            tick(vt[i].vld, vt[i].x0, vt[i].x1);
            chk($sformatf("impulse[%0d] valid", i), bus.out_valid, vt[i].e_vld);
            chk($sformatf("impulse[%0d] lane0", i), ly(0), vt[i].e0);
            chk($sformatf("impulse[%0d] lane1", i), ly(1), vt[i].e1);
            chk($sformatf("impulse[%0d] sat", i), bus.out_sat, vt[i].e_sat);
        end
        repeat (3) tick(1'b0, 0, 0);

        // Same impulse with in_valid pattern 1,0,0,1,...
        last0 = 0; last1 = 0; ob = 0;
        for (int i = 0; i < 26; i++) begin
            vh[i] = ((i % 3) == 0) && ((i / 3) < 8);
            tick(vh[i], (i == 0) ? 16384 : 0, 0);
            ev = (i >= 2) ? vh[i-2] : 1'b0;
            chk($sformatf("gap[%0d] valid", i), bus.out_valid, ev);
            if (ev) begin
                last0 = vt[ob+2].e0;
                last1 = vt[ob+2].e1;
                ob++;
            end
            chk($sformatf("gap[%0d] lane0", i), ly(0), last0);
            chk($sformatf("gap[%0d] lane1", i), ly(1), last1);
        end

        // Saturation at both rails.
        for (int t = 0; t < NTAPS; t++) hv[t] = 32767;
        load_bank();
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 32767, 32767);
            if (i >= 9) begin
                chk("sat_pos lane0", ly(0), 32767);
                chk("sat_pos lane1", ly(1), 32767);
                chk("sat_pos flags", bus.out_sat, 3);
            end
        end
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, -32768, -32768);
            if (i >= 9) begin
                chk("sat_neg lane0", ly(0), -32768);
                chk("sat_neg lane1", ly(1), -32768);
                chk("sat_neg flags", bus.out_sat, 3);
            end
        end

        // Coefficient double buffering while streaming.
        for (int t = 0; t < NTAPS; t++) hv[t] = 1024;
        load_bank();
        for (int i = 0; i < 10; i++) tick(1'b1, 16384, 16384);
        chk("swap settled lane0", ly(0), 6144);
        chk("swap settled lane1", ly(1), 6144);
        chk("swap settled sat", bus.out_sat, 0);
        for (int t = 0; t < NTAPS; t++) begin
            tick(1'b1, 16384, 16384, 1'b0, 1'b1, t, 0, 1'b0);
            chk($sformatf("shadow write %0d lane0", t), ly(0), 6144);
        end
        tick(1'b1, 16384, 16384, 1'b0, 1'b0, 0, 0, 1'b1);
        chk("commit+0 lane0", ly(0), 6144);
        tick(1'b1, 16384, 16384);
        chk("commit+1 lane0", ly(0), 6144);
        tick(1'b1, 16384, 16384);
        chk("commit+2 lane0", ly(0), 0);
        chk("commit+2 lane1", ly(1), 0);
        tick(1'b1, 16384, 16384, 1'b0, 1'b1, 0, 16384, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b1, 16384, 16384);
        chk("we+commit lane0", ly(0), 0);
        chk("we+commit lane1", ly(1), 0);
        tick(1'b1, 16384, 16384, 1'b0, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b1, 16384, 16384);
        chk("recommit lane0", ly(0), 8192);
        chk("recommit lane1", ly(1), 8192);

        // Flush one beat after the impulse truncates the tail.
        for (int t = 0; t < NTAPS; t++) hv[t] = (t + 1) * 1024;
        load_bank();
        tick(1'b0, 0, 0, 1'b1);
        repeat (3) tick(1'b0, 0, 0);
        tick(1'b1, 16384, 0);
        tick(1'b1, 0, 0, 1'b1);
        tick(1'b1, 0, 0);
        chk("flush head valid", bus.out_valid, 1);
        chk("flush head lane0", ly(0), 512);
        chk("flush head lane1", ly(1), 1024);
        tick(1'b1, 0, 0);
        chk("flush drop valid", bus.out_valid, 0);
        chk("flush drop hold", ly(1), 1024);
        tick(1'b1, 0, 0);
        chk("flush tail valid", bus.out_valid, 1);
        chk("flush tail lane0", ly(0), 0);
        chk("flush tail lane1", ly(1), 0);

        // Asynchronous reset mid-stream.
        repeat (2) tick(1'b0, 0, 0);
        for (int i = 0; i < 4; i++) tick(1'b1, 16384, 16384);
        chk("pre-rst lane0", ly(0), 3072);
        chk("pre-rst lane1", ly(1), 5120);
        #1;
        rst = 1'b1;
        #1;
        chk("async rst valid", bus.out_valid, 0);
        chk("async rst data", bus.out_data, 0);
        chk("async rst sat", bus.out_sat, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick(1'b1, 16384, 16384);
        chk("post-rst valid", bus.out_valid, 1);
        chk("post-rst active bank", bus.out_data, 0);
        tick(1'b1, 16384, 16384, 1'b0, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b1, 16384, 16384);
        chk("post-rst shadow bank", bus.out_data, 0);

        // Random beats against the reference model.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < NTAPS; t++) hv[t] = int'($urandom_range(0, 8192)) - 4096;
        load_bank();
        for (int t = 0; t < NTAPS; t++) ah[t] = hv[t];
        xs.delete();
        eq.delete();
        eq.push_back('{1'b0, 0, 0, 2'b00});
        eq.push_back('{1'b0, 0, 0, 2'b00});
        last0 = ly(0);
        last1 = ly(1);
        for (int i = 0; i < 502; i++) begin
            logic vld, fl, s0, s1;
            int   x0, x1;
            exp_t e;
            vld = (i < 500) && ($urandom_range(0, 3) != 0);
            fl  = (i < 500) && ($urandom_range(0, 39) == 0);
            x0  = int'($urandom_range(0, 65535)) - 32768;
            x1  = int'($urandom_range(0, 65535)) - 32768;
            e   = '{1'b0, 0, 0, 2'b00};
            if (fl) begin
                xs.delete();
            end else if (vld) begin
                xs.push_back(x0);
                ref_y(xs.size() - 1, e.y0, s0);
                xs.push_back(x1);
                ref_y(xs.size() - 1, e.y1, s1);
                e.vld = 1'b1;
                e.sat = {s1, s0};
            end
            eq.push_back(e);
            tick(vld, x0, x1, fl);
            e = eq.pop_front();
            chk($sformatf("rand[%0d] valid", i), bus.out_valid, e.vld);
            if (e.vld) begin
                last0 = e.y0;
                last1 = e.y1;
                chk($sformatf("rand[%0d] sat", i), bus.out_sat, e.sat);
            end
            chk($sformatf("rand[%0d] lane0", i), ly(0), last0);
            chk($sformatf("rand[%0d] lane1", i), ly(1), last1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
